// File: rtl/uart_loader_if.sv
// Instruction-memory write port driven by the UART program loader.
// The loader owns the master side; the instruction memory listens on the slave side.
interface uart_loader_if;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;

    modport master (output imem_we, output imem_addr, output imem_din);
    modport slave  (input  imem_we, input  imem_addr, input  imem_din);
endinterface

// File: rtl/uart_loader.sv
// Boot loader: receives a count-prefixed little-endian program image over 8N1 UART,
// writes it to instruction memory from address 0 and holds the core in reset until done.
module uart_loader #(
    parameter int CLK_PER_BIT = 868,
    parameter int MAX_WORDS   = 16384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    uart_loader_if.master mem,
    output logic          loading,
    output logic          done,
    output logic          error,
    output logic          core_rst
);

    localparam int          CNT_W     = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_HDR, LD_DATA, LD_DONE, LD_ERR}    ld_state_t;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] bit_timer, bit_timer_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_valid, byte_valid_n;
    logic             frame_err_n;

    ld_state_t        ld_state, ld_state_n;
    logic [1:0]       byte_cnt, byte_cnt_n;
    logic [23:0]      word_buf, word_buf_n;
    logic [31:0]      count, count_n;
    logic [31:0]      idx, idx_n;
    logic             we_q, we_n;
    logic [31:0]      addr_q, addr_n;
    logic [31:0]      din_q, din_n;
    logic [31:0]      rx_word;

    // Two-flop synchronizer; the line idles high so it resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            bit_timer  <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            bit_timer  <= bit_timer_n;
            bit_idx    <= bit_idx_n;
            rx_shift   <= rx_shift_n;
            byte_valid <= byte_valid_n;
        end
    end

    // Sampling happens when the bit timer reaches zero; the stop-bit sample
    // returns straight to IDLE so a back-to-back start bit is not missed.
    always_comb begin
        rx_state_n   = rx_state;
        bit_timer_n  = bit_timer;
        bit_idx_n    = bit_idx;
        rx_shift_n   = rx_shift;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_n  = RX_START;
                    bit_timer_n = HALF_LAST;
                end
            end
            RX_START: begin
                if (bit_timer == '0) begin
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n  = RX_DATA;
                        bit_timer_n = BIT_LAST;
                        bit_idx_n   = '0;
                    end
                end else begin
                    bit_timer_n = bit_timer - 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_timer == '0) begin
                    rx_shift_n  = {rx_sync, rx_shift[7:1]};
                    bit_timer_n = BIT_LAST;
                    if (bit_idx == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_timer_n = bit_timer - 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_timer == '0) begin
                    rx_state_n   = RX_IDLE;
                    byte_valid_n = rx_sync;
                    frame_err_n  = !rx_sync;
                end else begin
                    bit_timer_n = bit_timer - 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign rx_word = {rx_shift, word_buf};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state <= LD_HDR;
            byte_cnt <= '0;
            word_buf <= '0;
            count    <= '0;
            idx      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            ld_state <= ld_state_n;
            byte_cnt <= byte_cnt_n;
            word_buf <= word_buf_n;
            count    <= count_n;
            idx      <= idx_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            din_q    <= din_n;
        end
    end

    // Completion is judged in the write cycle itself, using the already
    // incremented index, so done follows the final write by one cycle.
    always_comb begin
        ld_state_n = ld_state;
        byte_cnt_n = byte_cnt;
        word_buf_n = word_buf;
        count_n    = count;
        idx_n      = idx;
        we_n       = 1'b0;
        addr_n     = addr_q;
        din_n      = din_q;
        unique case (ld_state)
            LD_HDR: begin
                if (frame_err_n) begin
                    ld_state_n = LD_ERR;
                end else if (byte_valid) begin
                    byte_cnt_n = byte_cnt + 2'd1;
                    word_buf_n = {rx_shift, word_buf[23:8]};
                    if (byte_cnt == 2'd3) begin
                        if (rx_word == '0) begin
                            ld_state_n = LD_DONE;
                        end else if (rx_word > MAX_W) begin
                            ld_state_n = LD_ERR;
                        end else begin
                            ld_state_n = LD_DATA;
                            count_n    = rx_word;
                            idx_n      = '0;
                        end
                    end
                end
            end
            LD_DATA: begin
                if (frame_err_n) begin
                    ld_state_n = LD_ERR;
                end else if (we_q && idx == count) begin
                    ld_state_n = LD_DONE;
                end else if (byte_valid) begin
                    byte_cnt_n = byte_cnt + 2'd1;
                    word_buf_n = {rx_shift, word_buf[23:8]};
                    if (byte_cnt == 2'd3) begin
                        we_n   = 1'b1;
                        addr_n = {idx[29:0], 2'b00};
                        din_n  = rx_word;
                        idx_n  = idx + 32'd1;
                    end
                end
            end
            LD_DONE: ld_state_n = LD_DONE;
            LD_ERR:  ld_state_n = LD_ERR;
            default: ld_state_n = LD_ERR;
        endcase
    end

    assign mem.imem_we   = we_q;
    assign mem.imem_addr = addr_q;
    assign mem.imem_din  = din_q;

    assign loading  = (ld_state == LD_HDR) || (ld_state == LD_DATA);
    assign done     = (ld_state == LD_DONE);
    assign error    = (ld_state == LD_ERR);
    assign core_rst = (ld_state != LD_DONE);

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: serial images are driven bit by bit and the
// resulting memory writes and status are compared with an image-level reference model.
module tb_uart_loader;

    localparam int CPB  = 4;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic loading, done, error, core_rst;

    uart_loader_if mem();

    uart_loader #(.CLK_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .mem      (mem),
        .loading  (loading),
        .done     (done),
        .error    (error),
        .core_rst (core_rst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          last_we_cyc;
    int          done_cyc;
    logic        clear_req = 1'b0;

    logic [7:0]  img[$];
    int          bad_idx;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed-write recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (clear_req) begin
            obs_addr.delete();
            obs_data.delete();
            last_we_cyc = -1;
            done_cyc    = -1;
        end else begin
            if (mem.imem_we) begin
                obs_addr.push_back(mem.imem_addr);
                obs_data.push_back(mem.imem_din);
                last_we_cyc = cyc;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic clear_monitor();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        #1 clear_req = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!stop_bit) repeat (3 * CPB) @(negedge clk);
    endtask

    // Reference model: interprets the byte stream as header count plus words.
    function automatic void build_model();
        int unsigned cnt;
        int base;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (bad_idx >= 0 && bad_idx < 4) begin
            exp_err = 1'b1;
            return;
        end
        if (img.size() < 4) return;
        cnt = {img[3], img[2], img[1], img[0]};
        if (cnt == 0) begin
            exp_done = 1'b1;
            return;
        end
        if (cnt > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            base = 4 + 4 * i;
            if (bad_idx >= base && bad_idx < base + 4) begin
                exp_err = 1'b1;
                return;
            end
            if (base + 3 >= img.size()) return;
            exp_addr.push_back(32'(i * 4));
            exp_data.push_back({img[base+3], img[base+2], img[base+1], img[base]});
        end
        exp_done = 1'b1;
    endfunction

    task automatic apply_stimulus(input bit do_reset);
        if (do_reset) reset_dut();
        clear_monitor();
        build_model();
        for (int k = 0; k < img.size(); k++) begin
            send_byte(img[k], (k == bad_idx) ? 1'b0 : 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int t = 0; t < 60 && !(done || error); t++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_results(input string tag);
        int n;
        check_output({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check_output($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
        end
        check_output({tag, "_done"},     32'(done),     32'(exp_done));
        check_output({tag, "_error"},    32'(error),    32'(exp_err));
        check_output({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
        check_output({tag, "_loading"},  32'(loading),  32'(!(exp_done || exp_err)));
        if (exp_done && exp_addr.size() > 0) begin
            check_output({tag, "_done_lat"}, 32'(done_cyc - last_we_cyc), 32'd1);
            check_output({tag, "_addr_hold"}, mem.imem_addr, exp_addr[exp_addr.size()-1]);
        end
    endtask

    task automatic random_words(input int words);
        for (int i = 0; i < 4 * words; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int cnt;
        $display("[TB] starting uart_loader bench");

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check_output("rst_we",       32'(mem.imem_we), 32'd0);
        check_output("rst_addr",     mem.imem_addr,    32'd0);
        check_output("rst_din",      mem.imem_din,     32'd0);
        check_output("rst_loading",  32'(loading),     32'd1);
        check_output("rst_done",     32'(done),        32'd0);
        check_output("rst_error",    32'(error),       32'd0);
        check_output("rst_core_rst", 32'(core_rst),    32'd1);
        rst = 1'b1;

        // Two-word directed image
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h80, 8'h00, 8'h00};
        bad_idx = -1;
        apply_stimulus(1'b1);
        check_results("basic");
        if (obs_data.size() == 2) begin
            check_output("basic_word0", obs_data[0], 32'h00100013);
            check_output("basic_word1", obs_data[1], 32'h00008093);
        end

        // Empty image
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        bad_idx = -1;
        apply_stimulus(1'b1);
        check_results("zero");

        // Oversized count, trailing bytes must be discarded
        img = '{8'h09, 8'h00, 8'h00, 8'h00};
        random_words(2);
        bad_idx = -1;
        apply_stimulus(1'b1);
        check_results("oversize");

        // Framing error on the second byte of the first data word
        img = '{8'h02, 8'h00, 8'h00, 8'h00};
        random_words(2);
        bad_idx = 5;
        apply_stimulus(1'b1);
        check_results("framing");

        // Short low glitch on an idle line followed by a one-word image
        reset_dut();
        repeat (4) @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        check_output("glitch_loading", 32'(loading), 32'd1);
        check_output("glitch_error",   32'(error),   32'd0);
        img = '{8'h01, 8'h00, 8'h00, 8'h00};
        random_words(1);
        bad_idx = -1;
        apply_stimulus(1'b0);
        check_results("glitch");

        // Reset pulsed mid-image, then a fresh one-word image
        reset_dut();
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55};
        for (int k = 0; k < img.size(); k++) send_byte(img[k], 1'b1);
        #2 rst = 1'b0;
        #1;
        check_output("abort_loading",  32'(loading),     32'd1);
        check_output("abort_done",     32'(done),        32'd0);
        check_output("abort_core_rst", 32'(core_rst),    32'd1);
        check_output("abort_we",       32'(mem.imem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        img = '{8'h01, 8'h00, 8'h00, 8'h00};
        random_words(1);
        bad_idx = -1;
        apply_stimulus(1'b0);
        check_results("abort");

        // Randomized images, first one at full capacity
        for (int r = 0; r < 6; r++) begin
            cnt = (r == 0) ? MAXW : int'($urandom_range(1, MAXW));
            img = '{8'(cnt), 8'h00, 8'h00, 8'h00};
            random_words(cnt);
            bad_idx = -1;
            apply_stimulus(1'b1);
            check_results($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
